// File: rtl/collatz_range_driver.sv
// collatz_range_driver: sweeps RAM_WORDS consecutive start values through an
// external Collatz engine, measures each sequence length and stores it in an
// on-chip result RAM readable through a registered port.
// Optional feature macro: COLLATZ_TIMEOUT_EN (per-entry timeout + overflow flag).
module collatz_range_driver #(
   parameter int RAM_WORDS  = 256,
   parameter int ADDR_BITS  = 8,
   parameter int COUNT_BITS = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  go,
   input  logic [31:0]           start,
   output logic                  busy,
   output logic                  done,
   output logic                  overflow,
   input  logic [ADDR_BITS-1:0]  raddr,
   output logic [COUNT_BITS-1:0] rcount,
   output logic                  cgo,
   output logic [31:0]           cn,
   input  logic [31:0]           cdout
);

   typedef enum logic [1:0] {IDLE, LOAD, COUNT} state_t;

   // Largest count value that still leaves room for the +1 of the stored length.
   localparam logic [COUNT_BITS-1:0] CNT_LIMIT = {{(COUNT_BITS-1){1'b1}}, 1'b0};

   state_t                state, state_nx;
   logic [31:0]           cur;
   logic [ADDR_BITS-1:0]  idx;
   logic [COUNT_BITS-1:0] cnt;
   logic                  capture;
   logic                  last;
   logic                  tmo;
   logic                  wr_en;
   logic [COUNT_BITS-1:0] wr_data;
   logic [COUNT_BITS-1:0] mem [RAM_WORDS];

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   // Next-state logic, engine handshake outputs and RAM write strobe.
   always_comb begin
      state_nx = state;
      capture  = 1'b0;
      tmo      = 1'b0;
      wr_en    = 1'b0;
      wr_data  = cnt + COUNT_BITS'(1);
      last     = (idx == ADDR_BITS'(RAM_WORDS - 1));
      busy     = (state != IDLE);
      cgo      = (state == LOAD);
      cn       = (state == LOAD) ? cur : 32'd0;
      case (state)
         IDLE: begin
            if (go) begin
               capture  = 1'b1;
               state_nx = LOAD;
            end
         end
         LOAD: state_nx = COUNT;
         COUNT: begin
`ifdef COLLATZ_TIMEOUT_EN
            tmo = (cnt == CNT_LIMIT) && (cdout != 32'd1);
`endif
            // Termination is judged by the iteration value alone; the engine's
            // own done flag is stale right after a load and is ignored.
            if (cdout == 32'd1 || tmo) begin
               wr_en    = 1'b1;
               wr_data  = tmo ? {COUNT_BITS{1'b1}} : cnt + COUNT_BITS'(1);
               state_nx = last ? IDLE : LOAD;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // Run bookkeeping: current start value, RAM index, length counter, done flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cur  <= 32'd0;
         idx  <= '0;
         cnt  <= '0;
         done <= 1'b0;
      end else begin
         if (capture) begin
            cur  <= start;
            idx  <= '0;
            done <= 1'b0;
         end
         if (state == LOAD) cnt <= '0;
         if (state == COUNT) begin
            cnt <= cnt + COUNT_BITS'(1);
            if (wr_en) begin
               if (last) begin
                  done <= 1'b1;
               end else begin
                  idx <= idx + ADDR_BITS'(1);
                  cur <= cur + 32'd1;
               end
            end
         end
      end
   end

`ifdef COLLATZ_TIMEOUT_EN
   logic ovf;

   // Sticky timeout flag, cleared when a new run is accepted.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)        ovf <= 1'b0;
      else if (capture) ovf <= 1'b0;
      else if (tmo)     ovf <= 1'b1;
   end

   assign overflow = ovf;
`else
   assign overflow = 1'b0;
`endif

   // Result RAM write port; contents survive reset.
   always_ff @(posedge clk) begin
      if (wr_en) mem[idx] <= wr_data;
   end

   // Registered read port; a same-address write in the same cycle returns old data.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) rcount <= '0;
      else       rcount <= mem[raddr];
   end

endmodule

// File: tb/tb_collatz_range_driver.sv
// Testbench for collatz_range_driver: behavioural Collatz engine, scoreboards
// for engine loads (cn) and result reads (rcount), directed sweeps.
module tb_collatz_range_driver;

   localparam int RW = 8;
   localparam int AB = 3;
`ifdef COLLATZ_TIMEOUT_EN
   localparam int CB = 8;
`else
   localparam int CB = 16;
`endif

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          go = 1'b0;
   logic [31:0]   start = 32'd0;
   logic          busy, done, overflow;
   logic [AB-1:0] raddr = '0;
   logic [CB-1:0] rcount;
   logic          cgo;
   logic [31:0]   cn;
   logic [31:0]   eng = 32'd0;

   int tests = 0;
   int failed = 0;
   int cgo_cnt = 0;
   logic rd_en = 1'b0;
   logic rd_pend = 1'b0;
   int rd_q[$];
   logic [31:0] cn_q[$];
   int exp_len[RW];

   collatz_range_driver #(.RAM_WORDS(RW), .ADDR_BITS(AB), .COUNT_BITS(CB)) dut (
      .clk(clk), .reset(reset), .go(go), .start(start), .busy(busy), .done(done),
      .overflow(overflow), .raddr(raddr), .rcount(rcount), .cgo(cgo), .cn(cn),
      .cdout(eng)
   );

   always #5 clk = ~clk;

   // Behavioural engine: loads on cgo, otherwise one Collatz step per clock.
   always @(posedge clk) begin
      if (cgo)         eng <= cn;
      else if (eng[0]) eng <= eng * 32'd3 + 32'd1;
      else             eng <= eng >> 1;
   end

   always @(posedge clk) rd_pend <= rd_en;

   task automatic check(input string name, input longint act, input longint exp);
      tests++;
      if (act != exp) begin
         failed++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Monitor: compares every engine load and every returned read against the queues.
   always @(negedge clk) begin
      if (rd_pend) begin
         if (rd_q.size() == 0) check("rcount_unexpected", 1, 0);
         else                  check("rcount", rcount, rd_q.pop_front());
      end
      if (cgo) begin
         cgo_cnt++;
         if (cn_q.size() == 0) check("cgo_unexpected", cn, 0);
         else                  check("cn", cn, cn_q.pop_front());
      end
   end

   task automatic run(input logic [31:0] s, input int exp_busy, input bit midgo,
                      input bit exp_ovf);
      int n;
      for (int i = 0; i < RW; i++) cn_q.push_back(s + 32'(i));
      @(negedge clk); go = 1'b1; start = s;
      @(negedge clk); go = 1'b0;
      check("busy_after_go", busy, 1);
      check("done_cleared", done, 0);
      n = 0;
      while (busy && n < 5000) begin
         n++;
         go = midgo && (n == 10);
         if (go) start = 32'd100;
         @(negedge clk);
      end
      go = 1'b0;
      check("busy_cycles", n, exp_busy);
      check("done", done, 1);
      check("overflow", overflow, exp_ovf);
      check("cn_q_drained", cn_q.size(), 0);
   endtask

   task automatic read_all();
      for (int i = 0; i < RW; i++) begin
         @(negedge clk);
         raddr = AB'(i);
         rd_en = 1'b1;
         rd_q.push_back(exp_len[i]);
      end
      @(negedge clk); rd_en = 1'b0;
      @(negedge clk);
      check("rd_q_drained", rd_q.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_overflow", overflow, 0);
      check("reset_cgo", cgo, 0);
      check("reset_cn", cn, 0);
      check("reset_rcount", rcount, 0);
      reset = 1'b0;

      // Sweep 1..8.
      exp_len = '{1, 2, 8, 3, 6, 9, 17, 4};
      run(32'd1, 58, 1'b0, 1'b0);
      check("cgo_pulses", cgo_cnt, 8);
      read_all();

      // Restart after done: 27..34 overwrites the RAM.
      exp_len = '{112, 19, 19, 19, 107, 6, 27, 14};
      run(32'd27, 331, 1'b0, 1'b0);
      read_all();

      // go with start=100 mid-run is ignored.
      exp_len = '{1, 2, 8, 3, 6, 9, 17, 4};
      run(32'd1, 58, 1'b1, 1'b0);
      read_all();

      // Asynchronous reset between edges aborts the run at once.
      for (int i = 0; i < RW; i++) cn_q.push_back(32'd27 + 32'(i));
      @(negedge clk); go = 1'b1; start = 32'd27;
      @(negedge clk); go = 1'b0;
      repeat (20) @(negedge clk);
      @(posedge clk); #2 reset = 1'b1;
      #1;
      check("async_reset_busy", busy, 0);
      check("async_reset_done", done, 0);
      check("async_reset_cgo", cgo, 0);
      cn_q.delete();
      @(negedge clk); @(negedge clk); reset = 1'b0;
      run(32'd1, 58, 1'b0, 1'b0);
      read_all();

`ifdef COLLATZ_TIMEOUT_EN
      // start=0 never reaches 1: entry 0 times out with all-ones.
      exp_len = '{255, 1, 2, 8, 3, 6, 9, 17};
      run(32'd0, 309, 1'b0, 1'b1);
      read_all();
`endif

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
